// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter
// Description : Round-robin arbiter sharing one clocked multiplier among
//               N_REQ requesters, one operation in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         resp_valid,
    input  logic [N_REQ-1:0]         resp_ready,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     busy,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_c
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_owner;
    logic [CNT_W-1:0] r_cnt;

    logic             w_found;
    logic [PTR_W-1:0] w_winner;
    logic [PTR_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && r_state == ST_IDLE && w_found) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            resp_product <= '0;
            resp_valid   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        mul_a   <= req_a[int'(w_winner)*WIDTH +: WIDTH];
                        mul_b   <= req_b[int'(w_winner)*WIDTH +: WIDTH];
                        r_owner <= w_winner;
                        r_cnt   <= CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        resp_product <= mul_c;
                        resp_valid   <= ONE_HOT0 << r_owner;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready[r_owner]) begin
                        resp_valid <= '0;
                        r_ptr      <= (r_owner == PTR_LAST) ? '0 : r_owner + PTR_W'(1);
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
